// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multi-digit seven-segment scan driver for common-anode displays.
//   Hex-decodes a DIGITS-wide nibble vector and time-multiplexes it onto a
//   shared active-low segment bus, strobing one active-low anode at a time.
//   New data is loaded into pending registers and promoted to the displayed
//   (shadow) registers only at a frame boundary, so a frame never mixes old
//   and new digits.
//
//   Parameters:
//     DIGITS       number of digits scanned (1..8)
//     REFRESH_DIV  clk cycles each digit is held (>= 1)
//
//   Ports:
//     clk         system clock
//     reset       synchronous, active-high reset
//     value       hex data, digit i = value[4i+3:4i], digit 0 rightmost
//     dp_in       per-digit decimal-point request, active-high
//     load        single-cycle strobe capturing value/dp_in
//     enable      1 = scan, 0 = display dark with scan frozen
//     seg         segments a..g (seg[0]=a .. seg[6]=g), active-low
//     dp          decimal point, active-low
//     an          anode selects, active-low, an[i] selects digit i
//     frame_done  one-cycle pulse following each frame boundary
//
//   Build option:
//     SEG_LZB_EN  when defined, leading zero digits (from DIGITS-1 down,
//                 never digit 0) are blanked; dp and anode are unaffected.

module seg7_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [0:6]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] CNT_LAST = PW'(REFRESH_DIV - 1);

  // Active-low a..g, a in the leftmost bit.
  function automatic logic [0:6] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [PW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_flag;
  logic [4*DIGITS-1:0]   shd_val;
  logic [DIGITS-1:0]     shd_dp;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            nib;
  logic                  nib_dp;
  logic [DIGITS-1:0]     an_sel;
  logic [0:6]            seg_next;

  always_comb begin
    tick     = enable && (cnt == CNT_LAST);
    boundary = tick && (idx == IDX_LAST);
  end

  // Digit currently addressed by idx: nibble, dp request and anode pattern.
  always_comb begin
    nib    = '0;
    nib_dp = 1'b0;
    an_sel = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == i[IW-1:0]) begin
        nib       = shd_val[4*i +: 4];
        nib_dp    = shd_dp[i];
        an_sel[i] = 1'b0;
      end
    end
  end

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] lead_zero;
  logic              run;
  logic              blank;

  // run stays high while every digit from the top down to i is zero;
  // digit 0 is excluded so a zero value still shows a single 0.
  always_comb begin
    lead_zero = '0;
    run       = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      run          = run && (shd_val[4*i +: 4] == 4'h0);
      lead_zero[i] = run;
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == i[IW-1:0]) blank = lead_zero[i];
    end
    seg_next = blank ? '1 : hex7(nib);
  end
`else
  always_comb begin
    seg_next = hex7(nib);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      shd_val    <= '0;
      shd_dp     <= '0;
      seg        <= '1;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;

      if (tick) begin
        cnt <= '0;
        idx <= boundary ? '0 : idx + 1'b1;
      end else if (enable) begin
        cnt <= cnt + 1'b1;
      end

      // A load coinciding with the boundary bypasses pending and goes
      // straight to the shadow, superseding any older pending data.
      if (boundary && load) begin
        shd_val   <= value;
        shd_dp    <= dp_in;
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b0;
      end else if (boundary && pend_flag) begin
        shd_val   <= pend_val;
        shd_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end

      if (enable) begin
        seg <= seg_next;
        dp  <= ~nib_dp;
        an  <= an_sel;
      end else begin
        seg <= '1;
        dp  <= 1'b1;
        an  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver: a DIGITS=4 / REFRESH_DIV=4 instance
//   for scanning, double buffering, enable and reset behaviour, plus a
//   DIGITS=1 / REFRESH_DIV=1 instance for the every-cycle boundary case.
//   Expected values are hand-derived; pcount numbers posedges after reset.

module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        enable;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  logic [0:6]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        frame_done1;

  int pcount = -3;
  int n_chk  = 0;
  int n_fail = 0;

`ifdef SEG_LZB_EN
  localparam logic [0:6] ZERO_TOP = 7'b1111111;
`else
  localparam logic [0:6] ZERO_TOP = 7'b0000001;
`endif

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .enable(enable), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  seg7_scan_driver #(.DIGITS(1), .REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .value(value[3:0]), .dp_in(dp_in[0:0]),
    .load(load), .enable(enable), .seg(seg1), .dp(dp1), .an(an1),
    .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pcount <= pcount + 1;

  initial begin
    #100000;
    $error("FAIL watchdog: pcount %0d expected finish", pcount);
    $fatal(1, "timeout");
  end

  task automatic at(input int n);
    while (pcount < n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] e_an,
                     input logic [0:6] e_seg, input logic e_dp, input logic e_fd);
    n_chk++;
    assert (an === e_an) else begin
      n_fail++; $error("FAIL %s an: got %b expected %b", tag, an, e_an);
    end
    n_chk++;
    assert (seg === e_seg) else begin
      n_fail++; $error("FAIL %s seg: got %b expected %b", tag, seg, e_seg);
    end
    n_chk++;
    assert (dp === e_dp) else begin
      n_fail++; $error("FAIL %s dp: got %b expected %b", tag, dp, e_dp);
    end
    n_chk++;
    assert (frame_done === e_fd) else begin
      n_fail++; $error("FAIL %s frame_done: got %b expected %b", tag, frame_done, e_fd);
    end
  endtask

  task automatic chk1(input string tag, input logic e_an,
                      input logic [0:6] e_seg, input logic e_fd);
    n_chk++;
    assert ({an1, seg1, frame_done1} === {e_an, e_seg, e_fd}) else begin
      n_fail++;
      $error("FAIL %s d1 an/seg/fd: got %b/%b/%b expected %b/%b/%b",
             tag, an1, seg1, frame_done1, e_an, e_seg, e_fd);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    load   = 1'b0;
    value  = 16'h0000;
    dp_in  = 4'b0000;

    // Reset held for three edges
    at(0);
    chk("reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    chk1("reset", 1'b1, 7'b1111111, 1'b0);
    reset = 1'b0;

    at(1);
    chk("first_scan", 4'b1110, 7'b0000001, 1'b1, 1'b0);
    chk1("first_scan", 1'b0, 7'b0000001, 1'b1);
    value = 16'h12AF; load = 1'b1;
    at(2);
    load = 1'b0;
    at(3);
    chk1("d1_direct_load", 1'b0, 7'b0111000, 1'b1);

    // Load before the first boundary takes effect only after it
    at(15); chk("pre_boundary", 4'b0111, 7'b0000001, 1'b1, 1'b0);
    at(16); chk("boundary1",    4'b0111, 7'b0000001, 1'b1, 1'b1);
    at(17); chk("f1_d0",        4'b1110, 7'b0111000, 1'b1, 1'b0);
    at(20); chk("f1_d0_hold",   4'b1110, 7'b0111000, 1'b1, 1'b0);
    at(21); chk("f1_d1",        4'b1101, 7'b0001000, 1'b1, 1'b0);
    at(25); chk("f1_d2",        4'b1011, 7'b0010010, 1'b1, 1'b0);
    at(29); chk("f1_d3",        4'b0111, 7'b1001111, 1'b1, 1'b0);
    at(32); chk("boundary2",    4'b0111, 7'b1001111, 1'b1, 1'b1);
    at(33); chk("f2_d0",        4'b1110, 7'b0111000, 1'b1, 1'b0);

    // Mid-frame loads: last wins, current frame undisturbed
    at(36); value = 16'h0003; load = 1'b1;
    at(37); load = 1'b0;
    chk("mid_d1_old",  4'b1101, 7'b0001000, 1'b1, 1'b0);
    at(40); value = 16'h2222; load = 1'b1;
    at(41); load = 1'b0;
    chk("mid_d2_old",  4'b1011, 7'b0010010, 1'b1, 1'b0);
    at(45); chk("mid_d3_old", 4'b0111, 7'b1001111, 1'b1, 1'b0);
    at(48); chk("boundary3",  4'b0111, 7'b1001111, 1'b1, 1'b1);
    at(49); chk("f3_d0",      4'b1110, 7'b0010010, 1'b1, 1'b0);
    at(53); chk("f3_d1",      4'b1101, 7'b0010010, 1'b1, 1'b0);
    at(61); chk("f3_d3",      4'b0111, 7'b0010010, 1'b1, 1'b0);

    // Disable at idx=2 with one prescaler count already used
    at(73); chk("pre_disable", 4'b1011, 7'b0010010, 1'b1, 1'b0);
    enable = 1'b0;
    at(74);
    chk("dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    chk1("d1_dark", 1'b1, 7'b1111111, 1'b0);
    at(77); value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    at(78); load = 1'b0;
    at(83); chk("dark_hold", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    enable = 1'b1;
    at(84); chk("resume",       4'b1011, 7'b0010010, 1'b1, 1'b0);
    at(86); chk("resume_hold",  4'b1011, 7'b0010010, 1'b1, 1'b0);
    at(87); chk("resume_next",  4'b0111, 7'b0010010, 1'b1, 1'b0);
    at(90); chk("boundary_dis", 4'b0111, 7'b0010010, 1'b1, 1'b1);

    // Load captured while dark shows with its decimal point
    at(91);  chk("dp_d0",  4'b1110, 7'b1001100, 1'b1, 1'b0);
    at(95);  chk("dp_d1",  4'b1101, 7'b0000110, 1'b1, 1'b0);
    at(99);  chk("dp_d2",  4'b1011, 7'b0010010, 1'b0, 1'b0);
    at(102); chk("dp_d2h", 4'b1011, 7'b0010010, 1'b0, 1'b0);
    at(103); chk("dp_d3",  4'b0111, 7'b1001111, 1'b1, 1'b0);

    // Reset mid-frame discards a pending load
    at(108); value = 16'hFFFF; dp_in = 4'b1111; load = 1'b1;
    at(109); load = 1'b0; dp_in = 4'b0100;
    at(110); reset = 1'b1;
    at(111); chk("reset_mid", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    at(112); reset = 1'b0;
    at(113); chk("post_reset",    4'b1110, 7'b0000001, 1'b1, 1'b0);
    at(128); chk("post_reset_bd", 4'b0111, 7'b0000001, 1'b1, 1'b1);
    at(129); chk("pending_gone",  4'b1110, 7'b0000001, 1'b1, 1'b0);

    // Load on the boundary cycle goes straight to the display
    at(143); value = 16'hABCD; load = 1'b1;
    at(144); load = 1'b0;
    chk("bd_load_edge", 4'b0111, 7'b0000001, 1'b1, 1'b1);
    at(145); chk("bd_load_d0", 4'b1110, 7'b1000010, 1'b1, 1'b0);
    at(149); chk("bd_load_d1", 4'b1101, 7'b0110001, 1'b1, 1'b0);
    at(150); value = 16'h0050; load = 1'b1;
    at(151); load = 1'b0;
    at(153); chk("bd_load_d2", 4'b1011, 7'b1100000, 1'b0, 1'b0);
    at(157); chk("bd_load_d3", 4'b0111, 7'b0001000, 1'b1, 1'b0);

    // Leading zeros (blanked only when SEG_LZB_EN is defined)
    at(161); chk("lz50_d0", 4'b1110, 7'b0000001, 1'b1, 1'b0);
    at(165); chk("lz50_d1", 4'b1101, 7'b0100100, 1'b1, 1'b0);
    at(169); chk("lz50_d2", 4'b1011, ZERO_TOP,   1'b0, 1'b0);
    at(173); chk("lz50_d3", 4'b0111, ZERO_TOP,   1'b1, 1'b0);
    at(175); value = 16'h0000; load = 1'b1;
    at(176); load = 1'b0;
    at(177); chk("lz00_d0", 4'b1110, 7'b0000001, 1'b1, 1'b0);
    at(181); chk("lz00_d1", 4'b1101, ZERO_TOP,   1'b1, 1'b0);
    at(185); chk("lz00_d2", 4'b1011, ZERO_TOP,   1'b0, 1'b0);
    at(189); chk("lz00_d3", 4'b0111, ZERO_TOP,   1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
